// File: rtl/i2s_sample_scheduler.sv
// I2S sample scheduler: buffers deserialized words and hands one word to the shifter per LR slot,
// substituting silence while idle, priming or starved, and requesting refills from the RPi.
module i2s_sample_scheduler #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 8,   // power of two, at least 4
   parameter int LOW_WATER   = 2,
   parameter int START_LEVEL = 4    // 1 .. DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   input  logic                     lr_clk,
   output logic [WIDTH-1:0]         sample_data,
   output logic                     sample_load,
   output logic                     sample_chan,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     irq,
   output logic                     underrun,
   output logic                     overflow,
   input  logic                     clr_flags,
   output logic [1:0]               state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);
   localparam logic [LW-1:0] START_LVL = LW'(START_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // lr_clk synchronizer and slot-boundary detector
   logic             lr_s1_q, lr_s1_d;
   logic             lr_s2_q, lr_s2_d;
   logic             lr_s3_q, lr_s3_d;
   logic             bnd_q, bnd_d;
   logic             bnd_chan_q, bnd_chan_d;

   // FIFO bookkeeping
   logic [WIDTH-1:0] fifo_mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             rdy_en_q, rdy_en_d;

   // control and registered outputs
   state_t           state_q, state_d;
   logic             stop_pend_q, stop_pend_d;
   logic [WIDTH-1:0] sample_data_q, sample_data_d;
   logic             sample_load_q, sample_load_d;
   logic             sample_chan_q, sample_chan_d;
   logic             irq_q, irq_d;
   logic             underrun_q, underrun_d;
   logic             overflow_q, overflow_d;

   logic             do_wr;
   logic             do_pop;
   logic             unr_evt;
   logic             ovf_evt;
   logic             full;

   assign full     = (level_q == FULL_LVL);
   // rdy_en_q keeps wr_ready low while reset is held and for the first edge after it
   assign wr_ready = rdy_en_q && !full;

   always_comb begin
      lr_s1_d    = lr_clk;
      lr_s2_d    = lr_s1_q;
      lr_s3_d    = lr_s2_q;
      bnd_d      = lr_s2_q ^ lr_s3_q;
      bnd_chan_d = lr_s2_q;
      rdy_en_d   = 1'b1;
   end

   always_comb begin
      state_d       = state_q;
      stop_pend_d   = 1'b0;
      do_pop        = 1'b0;
      unr_evt       = 1'b0;
      do_wr         = wr_valid && wr_ready;
      ovf_evt       = wr_valid && full;

      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_PRIME;
         end
         ST_PRIME: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (bnd_q && !bnd_chan_q && (level_q >= START_LVL)) begin
               // playback always begins on a left slot, and that slot already carries data
               state_d = ST_RUN;
               do_pop  = 1'b1;
            end
         end
         ST_RUN: begin
            stop_pend_d = !enable;
            if (bnd_q) begin
               if (!bnd_chan_q && stop_pend_q) begin
                  state_d     = ST_IDLE;
                  stop_pend_d = 1'b0;
               end else if (level_q != '0) begin
                  do_pop = 1'b1;
               end else begin
                  unr_evt = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = do_wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

      unique case ({do_wr, do_pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      sample_load_d = bnd_q;
      sample_data_d = sample_data_q;
      sample_chan_d = sample_chan_q;
      if (bnd_q) begin
         sample_chan_d = bnd_chan_q;
         sample_data_d = do_pop ? fifo_mem[rd_ptr_q] : '0;
      end

      irq_d      = (state_q != ST_IDLE) && (level_q <= LOW_LVL);
      // a set event coinciding with clr_flags leaves the flag set
      underrun_d = unr_evt || (underrun_q && !clr_flags);
      overflow_d = ovf_evt || (overflow_q && !clr_flags);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lr_s1_q       <= 1'b0;
         lr_s2_q       <= 1'b0;
         lr_s3_q       <= 1'b0;
         bnd_q         <= 1'b0;
         bnd_chan_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         rdy_en_q      <= 1'b0;
         state_q       <= ST_IDLE;
         stop_pend_q   <= 1'b0;
         sample_data_q <= '0;
         sample_load_q <= 1'b0;
         sample_chan_q <= 1'b0;
         irq_q         <= 1'b0;
         underrun_q    <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         lr_s1_q       <= lr_s1_d;
         lr_s2_q       <= lr_s2_d;
         lr_s3_q       <= lr_s3_d;
         bnd_q         <= bnd_d;
         bnd_chan_q    <= bnd_chan_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         rdy_en_q      <= rdy_en_d;
         state_q       <= state_d;
         stop_pend_q   <= stop_pend_d;
         sample_data_q <= sample_data_d;
         sample_load_q <= sample_load_d;
         sample_chan_q <= sample_chan_d;
         irq_q         <= irq_d;
         underrun_q    <= underrun_d;
         overflow_q    <= overflow_d;
      end
   end

   // storage needs no reset: the pointers define which entries are valid
   always_ff @(posedge clk) begin
      if (do_wr) fifo_mem[wr_ptr_q] <= wr_data;
   end

   assign sample_data = sample_data_q;
   assign sample_load = sample_load_q;
   assign sample_chan = sample_chan_q;
   assign level       = level_q;
   assign irq         = irq_q;
   assign underrun    = underrun_q;
   assign overflow    = overflow_q;
   assign state       = state_q;

endmodule

// File: doc/i2s_sample_scheduler.md
Name: i2s_sample_scheduler

Overview:
Sequences audio samples from the RPi deserializer into the I2S serializer. It holds a small sample FIFO and loads one word per LR slot, keeping left/right alignment. It inserts silence when idle or on underrun and raises a refill interrupt toward the RPi. It sits between the RPi data input path and the data shifter, runs on the divided system clock, and observes lr_clk only as a sampled input.

Parameters:
WIDTH, 16, sample word width
DEPTH, 8, FIFO depth in words; must be a power of two, at least 4
LOW_WATER, 2, irq asserts when level <= LOW_WATER
START_LEVEL, 4, minimum level before playback starts; must satisfy 1 <= START_LEVEL <= DEPTH

Ports:
clk  in  1  system clock; sole clock
reset  in  1  asynchronous, active-high reset
enable  in  1  playback request from the RPi side
wr_valid  in  1  deserializer has a complete word
wr_data  in  WIDTH  word from the deserializer
wr_ready  out  1  FIFO can accept a word
lr_clk  in  1  I2S word-select; 0 = left, 1 = right; asynchronous to clk
sample_data  out  WIDTH  word for the shifter; held between loads
sample_load  out  1  one-cycle strobe; shifter latches sample_data
sample_chan  out  1  channel of the current sample_data
level  out  log2(DEPTH)+1  FIFO occupancy
irq  out  1  refill request
underrun  out  1  sticky; a RUN slot found the FIFO empty
overflow  out  1  sticky; wr_valid arrived while the FIFO was full
clr_flags  in  1  clears underrun and overflow
state  out  2  0 = IDLE, 1 = PRIME, 2 = RUN

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, synchronizer flops 0. wr_ready becomes 1 on the first clk edge after reset deasserts.
- lr_clk path: 2-flop synchronizer, then a third flop for edge detect.
  - Either edge is a slot boundary; the slot's channel is the new synchronized value.
  - The boundary is registered at cycle N. sample_load and the updated sample_data/sample_chan appear at N+1.
  - The lr_clk half-period must be at least 6 clk cycles.
- FIFO:
  - wr_ready = (level < DEPTH), computed from registered level.
  - A write occurs when wr_valid and wr_ready are both high.
  - wr_valid while full drops the word and sets overflow.
  - A write and a pop in the same cycle both execute; level is unchanged.
  - Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- Boundary action, by state:
  - IDLE or PRIME: load zero (silence), no pop.
  - RUN with level > 0: pop head into sample_data.
  - RUN with level == 0: load zero and set underrun; state stays RUN.
  - sample_load pulses at every boundary, in every state.
- FSM:
  - IDLE -> PRIME: enable == 1, evaluated every cycle.
  - PRIME -> IDLE: enable == 0, immediate; the FIFO is retained.
  - PRIME -> RUN: only at a left-channel boundary (new lr == 0) with level >= START_LEVEL. That boundary pops, so frames always start on left.
  - RUN -> IDLE: enable == 0 is latched as a pending stop. The stop takes effect at the next left-channel boundary; that boundary loads zero and does not pop. The right slot already in progress completes normally.
  - enable re-asserted before the stop takes effect cancels the pending stop.
- irq: registered, = (state != IDLE) && (level <= LOW_WATER). Updates one cycle after level changes.
- Sticky flags: clr_flags clears both. A set event in the same cycle as clr_flags wins (flag = 1).
- reset asserted mid-operation: immediate return to the reset state; FIFO contents are discarded.

Test Plan:
- Reset, then enable=1, write 4 words 0x1111..0x4444, toggle lr_clk 0->1->0 (20 clk per half) -> state reaches RUN at the first falling-lr boundary. sample_data = 0x1111 with chan 0, then 0x2222 with chan 1. Each sample_load is 1 cycle wide, 4 cycles after the lr_clk change.
- Enter RUN with 4 words, then starve writes -> after 4 pops, the next boundaries load 0x0000 and underrun=1. irq=1 once level <= 2. clr_flags -> underrun=0.
- Write 9 words back-to-back with DEPTH=8 and no lr edges -> wr_ready=0 after the 8th word, overflow=1, level=8, 9th word absent from later output.
- In RUN, drop enable during a left slot -> the right slot still pops a FIFO word. The next left boundary loads 0x0000, state=IDLE, irq=0, remaining level preserved.
- enable=1 with level=3 (START_LEVEL=4) across 6 boundaries -> state stays PRIME, all loads 0x0000. 4th write then a left boundary -> RUN, first pop issued.
- Assert reset while in RUN with level=5 -> all outputs 0 immediately, level=0, state=IDLE.
